// File: rtl/mem_access_ctrl_if.sv
// Data-memory port between the MEM-stage access controller (master) and the memory (slave).
// A request is held until a single-cycle ack; rdata is valid with ack.
interface mem_access_ctrl_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_rdata;
    logic        dmem_ack;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        input  dmem_rdata, dmem_ack
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        output dmem_rdata, dmem_ack
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory access controller: turns load/store requests into req/ack bus
// transactions, stalls the pipeline meanwhile, and returns size/sign-extended load data.
module mem_access_ctrl #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [1:0]        mem_size,
    input  logic              mem_unsigned,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    output logic              stall,
    output logic [31:0]       load_data,
    output logic              load_valid,
    output logic              misaligned,
    output logic              bus_error,
    mem_access_ctrl_if.master bus
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       size_q;
    logic [1:0]       off_q;
    logic             uns_q;
    logic             bus_error_q;
    logic             access;
    logic             aligned;
    logic             start;
    logic             timeout;
    logic [3:0]       be_calc;
    logic [31:0]      wdata_calc;

    function automatic logic [31:0] extend_load(input logic [31:0] word, input logic [1:0] size,
                                                input logic [1:0] off, input logic uns);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{off, 3'b000} +: 8];
        h = off[1] ? word[31:16] : word[15:0];
        case (size)
            2'b00:   extend_load = uns ? {24'h0, b} : {{24{b[7]}}, b};
            2'b01:   extend_load = uns ? {16'h0, h} : {{16{h[15]}}, h};
            default: extend_load = word;
        endcase
    endfunction

    assign access  = mem_read | mem_write;
    assign timeout = (state == BUSY) && !bus.dmem_ack && (cnt == CNT_LAST);

    always_comb begin
        aligned    = 1'b1;
        be_calc    = 4'b1111;
        wdata_calc = wdata;
        case (mem_size)
            2'b00: begin
                be_calc    = 4'b0001 << addr[1:0];
                wdata_calc = {4{wdata[7:0]}};
            end
            2'b01: begin
                aligned    = ~addr[0];
                be_calc    = addr[1] ? 4'b1100 : 4'b0011;
                wdata_calc = {2{wdata[15:0]}};
            end
            default: aligned = (addr[1:0] == 2'b00);
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        stall      = 1'b0;
        misaligned = 1'b0;
        start      = 1'b0;
        case (state)
            IDLE: begin
                if (access && !aligned) begin
                    misaligned = 1'b1;
                end else if (access) begin
                    stall      = 1'b1;
                    start      = 1'b1;
                    state_next = BUSY;
                end
            end
            BUSY: begin
                stall = 1'b1;
                if (bus.dmem_ack || timeout) state_next = DONE;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (rst) begin
            stall      = 1'b0;
            misaligned = 1'b0;
            start      = 1'b0;
        end
    end

    // Request capture, completion and timeout handling.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt            <= '0;
            size_q         <= '0;
            off_q          <= '0;
            uns_q          <= 1'b0;
            bus_error_q    <= 1'b0;
            load_data      <= '0;
            load_valid     <= 1'b0;
            bus.dmem_req   <= 1'b0;
            bus.dmem_we    <= 1'b0;
            bus.dmem_addr  <= '0;
            bus.dmem_wdata <= '0;
            bus.dmem_be    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        bus.dmem_req   <= 1'b1;
                        bus.dmem_we    <= mem_write;
                        bus.dmem_addr  <= {addr[31:2], 2'b00};
                        bus.dmem_be    <= be_calc;
                        bus.dmem_wdata <= wdata_calc;
                        size_q         <= mem_size;
                        uns_q          <= mem_unsigned;
                        off_q          <= addr[1:0];
                        cnt            <= '0;
                    end
                end
                BUSY: begin
                    if (bus.dmem_ack) begin
                        bus.dmem_req <= 1'b0;
                        load_data    <= bus.dmem_we ? 32'h0
                                        : extend_load(bus.dmem_rdata, size_q, off_q, uns_q);
                        load_valid   <= ~bus.dmem_we;
                    end else if (timeout) begin
                        bus.dmem_req <= 1'b0;
                        load_data    <= '0;
                        bus_error_q  <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    load_valid  <= 1'b0;
                    bus_error_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus_error = bus_error_q & ~rst;

endmodule
